// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: detects PS/2 clock falls, assembles 11-bit frames and
// folds the 0xE0/0xF0 prefixes into one flagged scan code per key event.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_db,
  input  logic       ps2_data_db,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       break_flag,
  output logic       ext_flag,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          clk_q_r;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shreg_r, shreg_s;
  logic          par_r, par_s;
  logic [TW-1:0] tcnt_r, tcnt_s;
  logic          pend_break_r, pend_break_s;
  logic          pend_ext_r, pend_ext_s;
  logic [7:0]    scan_code_r, scan_code_s;
  logic          break_flag_r, break_flag_s;
  logic          ext_flag_r, ext_flag_s;
  logic          code_valid_r, code_valid_s;
  logic          frame_err_r, frame_err_s;
  logic          fall_s;
  logic          timeout_s;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  assign fall_s    = clk_q_r & ~ps2_clk_db;
  assign timeout_s = ~fall_s & (state_r != IDLE) & (tcnt_r == TLAST);

  // Next-state, frame assembly, prefix tracking and output pulse generation.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shreg_s      = shreg_r;
    par_s        = par_r;
    pend_break_s = pend_break_r;
    pend_ext_s   = pend_ext_r;
    scan_code_s  = scan_code_r;
    break_flag_s = break_flag_r;
    ext_flag_s   = ext_flag_r;
    code_valid_s = 1'b0;
    frame_err_s  = 1'b0;

    if ((state_r == IDLE) || fall_s) begin
      tcnt_s = {TW{1'b0}};
    end else begin
      tcnt_s = tcnt_r + TW'(1);
    end

    case (state_r)
      IDLE: begin
        // A fall with data high is a glitch, not a start bit.
        if (fall_s && !ps2_data_db) begin
          state_s   = DATA;
          bit_cnt_s = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (fall_s) begin
          shreg_s   = {ps2_data_db, shreg_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = PARITY;
          end else begin
            state_s = DATA;
          end
        end else if (timeout_s) begin
          state_s      = IDLE;
          frame_err_s  = 1'b1;
          pend_break_s = 1'b0;
          pend_ext_s   = 1'b0;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (fall_s) begin
          par_s   = ps2_data_db;
          state_s = STOP;
        end else if (timeout_s) begin
          state_s      = IDLE;
          frame_err_s  = 1'b1;
          pend_break_s = 1'b0;
          pend_ext_s   = 1'b0;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (fall_s) begin
          state_s = IDLE;
          if (ps2_data_db && odd_parity_ok(shreg_r, par_r)) begin
            if (shreg_r == 8'hF0) begin
              pend_break_s = 1'b1;
            end else if (shreg_r == 8'hE0) begin
              pend_ext_s = 1'b1;
            end else begin
              scan_code_s  = shreg_r;
              break_flag_s = pend_break_r;
              ext_flag_s   = pend_ext_r;
              code_valid_s = 1'b1;
              pend_break_s = 1'b0;
              pend_ext_s   = 1'b0;
            end
          end else begin
            frame_err_s  = 1'b1;
            pend_break_s = 1'b0;
            pend_ext_s   = 1'b0;
          end
        end else if (timeout_s) begin
          state_s      = IDLE;
          frame_err_s  = 1'b1;
          pend_break_s = 1'b0;
          pend_ext_s   = 1'b0;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; clk_q resets high so reset release is not a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      clk_q_r      <= 1'b1;
      bit_cnt_r    <= 3'd0;
      shreg_r      <= 8'h00;
      par_r        <= 1'b0;
      tcnt_r       <= {TW{1'b0}};
      pend_break_r <= 1'b0;
      pend_ext_r   <= 1'b0;
      scan_code_r  <= 8'h00;
      break_flag_r <= 1'b0;
      ext_flag_r   <= 1'b0;
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      clk_q_r      <= ps2_clk_db;
      bit_cnt_r    <= bit_cnt_s;
      shreg_r      <= shreg_s;
      par_r        <= par_s;
      tcnt_r       <= tcnt_s;
      pend_break_r <= pend_break_s;
      pend_ext_r   <= pend_ext_s;
      scan_code_r  <= scan_code_s;
      break_flag_r <= break_flag_s;
      ext_flag_r   <= ext_flag_s;
      code_valid_r <= code_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign scan_code  = scan_code_r;
  assign code_valid = code_valid_r;
  assign break_flag = break_flag_r;
  assign ext_flag   = ext_flag_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: frames are driven bit by bit, expected
// pulses are queued at the stop/timeout point and matched by a negedge monitor.
module tb_ps2_rx_frame;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk_db;
  logic       ps2_data_db;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       break_flag;
  logic       ext_flag;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    int         cyc;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  staged;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_fall = 0;
  bit   m_brk = 1'b0;
  bit   m_ext = 1'b0;

  ps2_rx_frame #(.TIMEOUT_CYCLES(200)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_db (ps2_clk_db),
    .ps2_data_db(ps2_data_db),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .break_flag (break_flag),
    .ext_flag   (ext_flag),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (code_valid || frame_err) begin
      checks++;
      if (code_valid && frame_err) begin
        failures++;
        $display("FAIL both_pulses cyc=%0d code_valid=1 frame_err=1, required at most one", cyc);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d code_valid=%0b frame_err=%0b scan=%02h, required none",
                 cyc, code_valid, frame_err, scan_code);
      end else begin
        e = exp_q.pop_front();
        if ((frame_err !== e.is_err) || (cyc != e.cyc) ||
            (!e.is_err && ((scan_code !== e.code) || (break_flag !== e.brk) || (ext_flag !== e.ext)))) begin
          failures++;
          $display("FAIL pulse got err=%0b cyc=%0d scan=%02h brk=%0b ext=%0b, required err=%0b cyc=%0d scan=%02h brk=%0b ext=%0b",
                   frame_err, cyc, scan_code, break_flag, ext_flag, e.is_err, e.cyc, e.code, e.brk, e.ext);
        end
      end
    end
  end

  // One PS/2 bit: data set while clock high, 20-cycle low then 20-cycle high.
  task automatic send_bit(input logic b, input bit arm);
    @(negedge clk);
    ps2_data_db = b;
    repeat (9) @(negedge clk);
    if (arm) begin
      staged.cyc = cyc + 1;
      exp_q.push_back(staged);
    end
    ps2_clk_db = 1'b0;
    last_fall  = cyc;
    repeat (20) @(negedge clk);
    ps2_clk_db = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    bit   arm;
    p   = ~(^d) ^ bad_par;
    arm = 1'b0;
    if (bad_par || bad_stop) begin
      staged = '{1'b1, 8'h00, 1'b0, 1'b0, 0};
      m_brk = 1'b0; m_ext = 1'b0; arm = 1'b1;
    end else if (d == 8'hF0) begin
      m_brk = 1'b1;
    end else if (d == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      staged = '{1'b0, d, m_brk, m_ext, 0};
      m_brk = 1'b0; m_ext = 1'b0; arm = 1'b1;
    end
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(p, 1'b0);
    send_bit(~bad_stop, arm);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ps2_clk_db = 1'b1; ps2_data_db = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({scan_code, code_valid, break_flag, ext_flag, frame_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_values got scan=%02h cv=%0b brk=%0b ext=%0b err=%0b, required all zero",
               scan_code, code_valid, break_flag, ext_flag, frame_err);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single;
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || scan_code !== 8'h1C || break_flag !== 1'b0) begin
      failures++;
      $display("FAIL single_1c pending=%0d scan=%02h brk=%0b, required 0 1c 0", exp_q.size(), scan_code, break_flag);
      exp_q.delete();
    end
  endtask

  task automatic test_prefixes;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || scan_code !== 8'h75 || break_flag !== 1'b1 || ext_flag !== 1'b1) begin
      failures++;
      $display("FAIL prefixes pending=%0d scan=%02h brk=%0b ext=%0b, required 0 75 1 1",
               exp_q.size(), scan_code, break_flag, ext_flag);
      exp_q.delete();
    end
  endtask

  task automatic test_errors;
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || scan_code !== 8'h75 || ext_flag !== 1'b1) begin
      failures++;
      $display("FAIL parity_err_hold pending=%0d scan=%02h ext=%0b, required 0 75 1", exp_q.size(), scan_code, ext_flag);
      exp_q.delete();
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || scan_code !== 8'h1C || break_flag !== 1'b0) begin
      failures++;
      $display("FAIL err_clears_prefix pending=%0d scan=%02h brk=%0b, required 0 1c 0", exp_q.size(), scan_code, break_flag);
      exp_q.delete();
    end
  endtask

  task automatic test_timeout;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    staged = '{1'b1, 8'h00, 1'b0, 1'b0, last_fall + 201};
    exp_q.push_back(staged);
    m_brk = 1'b0; m_ext = 1'b0;
    repeat (250) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_err pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    send_frame(8'h29, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || scan_code !== 8'h29 || ext_flag !== 1'b0) begin
      failures++;
      $display("FAIL timeout_recover pending=%0d scan=%02h ext=%0b, required 0 29 0", exp_q.size(), scan_code, ext_flag);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe;
    send_frame(8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    m_brk = 1'b0; m_ext = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if ({scan_code, code_valid, break_flag, ext_flag, frame_err} !== 12'h000) begin
      failures++;
      $display("FAIL midframe_reset got scan=%02h cv=%0b brk=%0b ext=%0b err=%0b, required all zero",
               scan_code, code_valid, break_flag, ext_flag, frame_err);
    end
    send_bit(1'b1, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (scan_code !== 8'h00 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL spurious_fall scan=%02h pending=%0d, required 00 0", scan_code, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || scan_code !== 8'h32 || break_flag !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back pending=%0d scan=%02h brk=%0b, required 0 32 0", exp_q.size(), scan_code, break_flag);
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefixes();
    test_errors();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached at cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
